// File: rtl/accel_arb_pkg.sv
// Shared types and defaults for the accelerator arbiter: FSM state encoding,
// parameter defaults and the id-width helper.
package accel_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    DONE      = 3'd4
  } arb_state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 255;

  // Width of a requester id; a single bit is kept even for degenerate sizes.
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/accel_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first asserted request found
// when scanning upward from ptr and wrapping modulo N_REQ.
module rr_picker
  import accel_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int ID_W = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  winner
);

  logic [ID_W-1:0] idx;

  // Scanning from the farthest offset down lets the nearest hit overwrite the rest.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr) + i) % N_REQ);
      if (req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/accel_arbiter.sv
// Shares one start/ready accelerator among N_REQ requesters with round-robin
// grant, operand latching, result capture and a per-job watchdog.
module accel_arbiter
  import accel_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int ID_W   = id_w(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_x,
  output logic [N_REQ-1:0]        ack,
  output logic                    err,
  output logic [DATA_W-1:0]       result,
  output logic                    busy,
  output logic [ID_W-1:0]         cur_id,
  output logic                    acc_start,
  output logic [DATA_W-1:0]       acc_x,
  input  logic                    acc_ready,
  input  logic [DATA_W-1:0]       acc_result
);

  localparam int WDOG_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t        state, next_state;
  logic [ID_W-1:0]   ptr, winner;
  logic              any_req, wdog_fire, timed_out;
  logic [DATA_W-1:0] x_reg;
  logic [WDOG_W-1:0] wdog;
  logic [DATA_W-1:0] slot_x [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      slot_x[i] = req_x[i*DATA_W +: DATA_W];
    end
  end

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req    (req),
    .ptr    (ptr),
    .any    (any_req),
    .winner (winner)
  );

  // wdog counts completed wait cycles, so the watchdog fires on the TIMEOUT-th one.
  assign wdog_fire = (TIMEOUT != 0) && (wdog == WDOG_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (any_req && acc_ready) next_state = START;
      START:     next_state = WAIT_LOW;
      WAIT_LOW:  if (wdog_fire) next_state = DONE;
                 else if (!acc_ready) next_state = WAIT_HIGH;
      WAIT_HIGH: if (wdog_fire || acc_ready) next_state = DONE;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr       <= '0;
      cur_id    <= '0;
      x_reg     <= '0;
      result    <= '0;
      wdog      <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req && acc_ready) begin
            cur_id <= winner;
            x_reg  <= slot_x[winner];
          end
        end
        START: begin
          wdog      <= '0;
          timed_out <= 1'b0;
        end
        WAIT_LOW, WAIT_HIGH: begin
          if (wdog_fire) begin
            result    <= '0;
            timed_out <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
            if (state == WAIT_HIGH && acc_ready) result <= acc_result;
          end
        end
        DONE: begin
          ptr <= (int'(cur_id) == N_REQ - 1) ? '0 : cur_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack = '0;
    if (state == DONE) ack[cur_id] = 1'b1;
    err       = (state == DONE) && timed_out;
    acc_start = (state == START);
    busy      = (state != IDLE);
  end

  assign acc_x = x_reg;

endmodule

// File: tb/tb_accel_arbiter.sv
// Scoreboard bench for accel_arbiter: two instances (default watchdog and
// TIMEOUT=8) each driven by a behavioural start/ready accelerator model.
module tb_accel_arbiter;

  typedef struct {
    int          inst;
    logic [3:0]  ack;
    logic [15:0] x;
    logic [15:0] res;
    logic        err;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  logic [1:0][3:0]  req;
  logic [1:0][63:0] req_x;
  logic [1:0][3:0]  ack;
  logic [1:0]       err;
  logic [1:0][15:0] result;
  logic [1:0]       busy;
  logic [1:0][1:0]  cur_id;
  logic [1:0]       m_start;
  logic [1:0][15:0] m_x;
  logic [1:0]       m_ready;
  logic [1:0][15:0] m_res;
  logic [1:0][15:0] m_op;
  logic [1:0]       m_hang;
  int               m_phase [2];
  int               m_cnt [2];
  int               m_lat [2];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   start_cnt [2];
  int   ack_cnt [2];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  accel_arbiter #(.N_REQ(4), .DATA_W(16), .TIMEOUT(255)) dut (
    .clock(clock), .reset(reset), .req(req[0]), .req_x(req_x[0]),
    .ack(ack[0]), .err(err[0]), .result(result[0]), .busy(busy[0]),
    .cur_id(cur_id[0]), .acc_start(m_start[0]), .acc_x(m_x[0]),
    .acc_ready(m_ready[0]), .acc_result(m_res[0])
  );

  accel_arbiter #(.N_REQ(4), .DATA_W(16), .TIMEOUT(8)) dut_wd (
    .clock(clock), .reset(reset), .req(req[1]), .req_x(req_x[1]),
    .ack(ack[1]), .err(err[1]), .result(result[1]), .busy(busy[1]),
    .cur_id(cur_id[1]), .acc_start(m_start[1]), .acc_x(m_x[1]),
    .acc_ready(m_ready[1]), .acc_result(m_res[1])
  );

  // Accelerator model: ready drops 2 cycles after start, rises m_lat cycles later
  // with result 3*x + 16'h1174; with m_hang set it ignores the start entirely.
  always @(posedge clock) begin
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        m_ready[m] <= 1'b1;
        m_phase[m] <= 0;
        m_cnt[m]   <= 0;
        m_res[m]   <= '0;
        m_op[m]    <= '0;
      end else begin
        case (m_phase[m])
          0: if (m_start[m] && !m_hang[m]) begin
               m_op[m]    <= m_x[m];
               m_cnt[m]   <= 1;
               m_phase[m] <= 1;
             end
          1: if (m_cnt[m] == 2) begin
               m_ready[m] <= 1'b0;
               m_cnt[m]   <= 1;
               m_phase[m] <= 2;
             end else begin
               m_cnt[m] <= m_cnt[m] + 1;
             end
          default: if (m_cnt[m] == m_lat[m]) begin
               m_ready[m] <= 1'b1;
               m_res[m]   <= 16'(m_op[m] * 16'd3 + 16'h1174);
               m_phase[m] <= 0;
             end else begin
               m_cnt[m] <= m_cnt[m] + 1;
             end
        endcase
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_start(input int m, input logic [15:0] x);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL start_unexpected: inst %0d acc_x %0h with nothing expected", m, x);
    end else if (sb[0].inst != m || x !== sb[0].x) begin
      n_fail++;
      $display("[TB] FAIL start_operand: inst %0d acc_x %0h expected inst %0d x %0h",
               m, x, sb[0].inst, sb[0].x);
    end
  endtask

  task automatic check_ack(input int m, input logic [3:0] a, input logic [15:0] r,
                           input logic e, input int outstanding);
    exp_t t;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL ack_unexpected: inst %0d ack %b result %0h err %b", m, a, r, e);
    end else begin
      t = sb.pop_front();
      if (t.inst != m || a !== t.ack || r !== t.res || e !== t.err || outstanding != 0) begin
        n_fail++;
        $display("[TB] FAIL ack_job: inst %0d ack %b result %0h err %b starts-acks %0d expected inst %0d ack %b result %0h err %b starts-acks 0",
                 m, a, r, e, outstanding, t.inst, t.ack, t.res, t.err);
      end
    end
  endtask

  // Monitor: samples on the falling edge, checks operands at start and jobs at ack.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        for (int m = 0; m < 2; m++) begin
          start_cnt[m] = 0;
          ack_cnt[m]   = 0;
        end
      end else begin
        for (int m = 0; m < 2; m++) begin
          if (m_start[m]) begin
            start_cnt[m]++;
            check_start(m, m_x[m]);
          end
          if (ack[m] != 4'b0) begin
            ack_cnt[m]++;
            check_ack(m, ack[m], result[m], err[m], start_cnt[m] - ack_cnt[m]);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input int m, input logic [3:0] r);
    req[m] = r;
  endtask

  task automatic set_x(input int m, input int slot, input logic [15:0] v);
    req_x[m][slot*16 +: 16] = v;
  endtask

  task automatic expect_job(input int m, input int id, input logic [15:0] x,
                            input logic [15:0] res, input logic e);
    exp_t t;
    t.inst = m;
    t.ack  = 4'(1 << id);
    t.x    = x;
    t.res  = res;
    t.err  = e;
    sb.push_back(t);
  endtask

  task automatic wait_acks(input int m, input int n);
    int  target = ack_cnt[m] + n;
    bit  done   = 0;
    for (int i = 0; i < 100 * n + 100 && !done; i++) begin
      step();
      if (ack_cnt[m] >= target) done = 1;
    end
    check_output("ack_wait", 32'(done), 32'd1);
  endtask

  task automatic wait_start(input int m, output int at_cyc);
    bit done = 0;
    at_cyc = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      if (m_start[m]) begin
        done   = 1;
        at_cyc = cyc;
      end
    end
    check_output("start_wait", 32'(done), 32'd1);
  endtask

  task automatic wait_ready_low(input int m);
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      if (!m_ready[m]) done = 1;
    end
    check_output("ready_low_wait", 32'(done), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_busy"},      32'(busy[0]),      32'd0);
    check_output({tag, "_ack"},       32'(ack[0]),       32'd0);
    check_output({tag, "_err"},       32'(err[0]),       32'd0);
    check_output({tag, "_result"},    32'(result[0]),    32'd0);
    check_output({tag, "_acc_start"}, 32'(m_start[0]),   32'd0);
    check_output({tag, "_cur_id"},    32'(cur_id[0]),    32'd0);
    check_output({tag, "_acc_x"},     32'(m_x[0]),       32'd0);
    check_output({tag, "_wd_busy"},   32'(busy[1]),      32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int cs, ca;
    req     = '0;
    req_x   = '0;
    m_hang  = '0;
    m_lat[0] = 20;
    m_lat[1] = 3;
    reset   = 1'b1;
    repeat (3) step();
    check_reset_state("reset");
    reset = 1'b0;
    set_x(0, 0, 16'h0001);
    set_x(0, 1, 16'h0010);
    set_x(0, 2, 16'h0040);
    set_x(0, 3, 16'h0100);
    step();

    $display("[TB] all four requesters held from reset");
    expect_job(0, 0, 16'h0001, 16'h1177, 1'b0);
    expect_job(0, 1, 16'h0010, 16'h11A4, 1'b0);
    expect_job(0, 2, 16'h0040, 16'h1234, 1'b0);
    expect_job(0, 3, 16'h0100, 16'h1474, 1'b0);
    expect_job(0, 0, 16'h0001, 16'h1177, 1'b0);
    expect_job(0, 1, 16'h0010, 16'h11A4, 1'b0);
    apply_stimulus(0, 4'b1111);
    wait_acks(0, 6);
    apply_stimulus(0, 4'b0000);
    step();

    $display("[TB] pointer at 2, requesters 1 and 3");
    expect_job(0, 3, 16'h0100, 16'h1474, 1'b0);
    expect_job(0, 1, 16'h0010, 16'h11A4, 1'b0);
    apply_stimulus(0, 4'b1010);
    wait_acks(0, 2);
    apply_stimulus(0, 4'b0000);
    step();

    $display("[TB] single request on slot 2");
    expect_job(0, 2, 16'h0040, 16'h1234, 1'b0);
    apply_stimulus(0, 4'b0100);
    step();
    check_output("start_latency", 32'(m_start[0]), 32'd1);
    check_output("start_operand", 32'(m_x[0]), 32'h0040);
    step();
    check_output("start_one_cycle", 32'(m_start[0]), 32'd0);
    wait_acks(0, 1);
    apply_stimulus(0, 4'b0000);
    step();
    check_output("busy_after_ack", 32'(busy[0]), 32'd0);
    check_output("ack_one_cycle", 32'(ack[0]), 32'd0);
    check_output("result_held", 32'(result[0]), 32'h1234);

    $display("[TB] request dropped mid-job, operand changed after grant");
    expect_job(0, 0, 16'h0001, 16'h1177, 1'b0);
    apply_stimulus(0, 4'b0001);
    wait_start(0, cs);
    set_x(0, 0, 16'hFFFF);
    wait_ready_low(0);
    repeat (5) step();
    apply_stimulus(0, 4'b0000);
    wait_acks(0, 1);
    repeat (30) step();
    check_output("starts_total", 32'(start_cnt[0]), 32'd10);
    check_output("acks_total", 32'(ack_cnt[0]), 32'd10);
    set_x(0, 0, 16'h0001);

    $display("[TB] reset during WAIT_HIGH");
    expect_job(0, 2, 16'h0040, 16'h1234, 1'b0);
    apply_stimulus(0, 4'b0100);
    wait_start(0, cs);
    wait_ready_low(0);
    repeat (3) step();
    reset = 1'b1;
    apply_stimulus(0, 4'b0000);
    step();
    check_reset_state("midjob_reset");
    sb.delete();
    reset = 1'b0;
    step();
    expect_job(0, 1, 16'h0010, 16'h11A4, 1'b0);
    expect_job(0, 3, 16'h0100, 16'h1474, 1'b0);
    apply_stimulus(0, 4'b1010);
    wait_acks(0, 2);
    apply_stimulus(0, 4'b0000);
    step();

    $display("[TB] watchdog instance: normal, timeout, normal");
    set_x(1, 1, 16'h0007);
    expect_job(1, 1, 16'h0007, 16'h1189, 1'b0);
    apply_stimulus(1, 4'b0010);
    wait_acks(1, 1);
    apply_stimulus(1, 4'b0000);
    step();
    m_hang[1] = 1'b1;
    set_x(1, 0, 16'h0005);
    expect_job(1, 0, 16'h0005, 16'h0000, 1'b1);
    apply_stimulus(1, 4'b0001);
    wait_start(1, cs);
    wait_acks(1, 1);
    ca = cyc;
    apply_stimulus(1, 4'b0000);
    check_output("wdog_latency", 32'(ca - cs), 32'd9);
    step();
    m_hang[1] = 1'b0;
    set_x(1, 1, 16'h0002);
    expect_job(1, 1, 16'h0002, 16'h117A, 1'b0);
    apply_stimulus(1, 4'b0010);
    wait_acks(1, 1);
    apply_stimulus(1, 4'b0000);
    repeat (5) step();

    check_output("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
